// File: rtl/cordic_multimode.sv
// Iterative circular CORDIC engine with run-time rotation/vectoring mode selection.
// x/y carry two guard bits internally and saturate on output; z wraps modulo 2^Width.
module cordic_multimode #(
  parameter int unsigned Width      = 16,
  parameter int unsigned Iterations = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_cordic_i,
  input  logic             mode_i,
  input  logic [Width-1:0] x0_i,
  input  logic [Width-1:0] y0_i,
  input  logic [Width-1:0] z0_i,
  output logic [Width-1:0] xn_o,
  output logic [Width-1:0] yn_o,
  output logic [Width-1:0] zn_o,
  output logic             busy_o,
  output logic             done_tick_cordic_o
);

  localparam int unsigned IterW = $clog2(Iterations);
  localparam int unsigned XW    = Width + 2;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  // Elaboration-only arctangent via power series; atan(1) is taken as pi/4 directly.
  function automatic real atan_pow2(input int i);
    real x, x2, term, acc;
    x = 1.0;
    for (int k = 0; k < i; k++) x = x / 2.0;
    x2   = x * x;
    term = x;
    acc  = 0.0;
    if (i == 0) begin
      acc = 0.7853981633974483;
    end else begin
      for (int k = 0; k < 40; k++) begin
        if (k % 2 == 0) acc = acc + term / real'(2 * k + 1);
        else            acc = acc - term / real'(2 * k + 1);
        term = term * x2;
      end
    end
    return acc;
  endfunction

  function automatic logic [Width-1:0] atan_entry(input int i);
    real    scale;
    longint v;
    scale = 1.0;
    for (int k = 0; k < int'(Width) - 2; k++) scale = scale * 2.0;
    v = longint'(atan_pow2(i) * scale);
    return v[Width-1:0];
  endfunction

  function automatic logic [Width-1:0] sat(input logic signed [XW-1:0] v);
    logic [Width-1:0] res;
    if ((&v[XW-1:Width-1]) || !(|v[XW-1:Width-1])) begin
      res = v[Width-1:0];
    end else if (v[XW-1]) begin
      res = {1'b1, {(Width-1){1'b0}}};
    end else begin
      res = {1'b0, {(Width-1){1'b1}}};
    end
    return res;
  endfunction

  logic [Width-1:0] w_atan [Iterations];

  for (genvar g = 0; g < Iterations; g++) begin : g_atan
    localparam logic [Width-1:0] AtanVal = atan_entry(int'(g));
    assign w_atan[g] = AtanVal;
  end

  state_e                  r_state, w_state_next;
  logic signed [XW-1:0]    r_x, r_y;
  logic [Width-1:0]        r_z;
  logic                    r_mode;
  logic [IterW-1:0]        r_iter;
  logic [Width-1:0]        r_xn, r_yn, r_zn;
  logic                    r_busy, r_done;

  logic                    w_load, w_step, w_finish;
  logic                    w_dpos;
  logic signed [XW-1:0]    w_xs, w_ys, w_x_next, w_y_next;
  logic [Width-1:0]        w_z_next, w_atan_cur;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_cordic_i) begin
          w_state_next = StIter;
          w_load       = 1'b1;
        end
      end
      StIter: begin
        w_step = 1'b1;
        if (r_iter == IterW'(Iterations - 1)) w_state_next = StDone;
      end
      StDone: begin
        w_finish     = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_atan_cur = '0;
    for (int k = 0; k < int'(Iterations); k++) begin
      if (r_iter == IterW'(k)) w_atan_cur = w_atan[k];
    end
  end

  // d = +1 rotates counter-clockwise: towards z = 0 (rotation) or y = 0 from below (vectoring).
  always_comb begin
    w_xs     = r_x >>> r_iter;
    w_ys     = r_y >>> r_iter;
    w_dpos   = r_mode ? r_y[XW-1] : ~r_z[Width-1];
    w_x_next = w_dpos ? (r_x - w_ys) : (r_x + w_ys);
    w_y_next = w_dpos ? (r_y + w_xs) : (r_y - w_xs);
    w_z_next = w_dpos ? (r_z - w_atan_cur) : (r_z + w_atan_cur);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_mode <= 1'b0;
      r_iter <= '0;
      r_xn   <= '0;
      r_yn   <= '0;
      r_zn   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_x    <= {{2{x0_i[Width-1]}}, x0_i};
        r_y    <= {{2{y0_i[Width-1]}}, y0_i};
        r_z    <= z0_i;
        r_mode <= mode_i;
        r_iter <= '0;
        r_busy <= 1'b1;
      end
      if (w_step) begin
        r_x    <= w_x_next;
        r_y    <= w_y_next;
        r_z    <= w_z_next;
        r_iter <= r_iter + 1'b1;
      end
      if (w_finish) begin
        r_xn   <= sat(r_x);
        r_yn   <= sat(r_y);
        r_zn   <= r_z;
        r_busy <= 1'b0;
      end
    end
  end

  assign xn_o               = r_xn;
  assign yn_o               = r_yn;
  assign zn_o               = r_zn;
  assign busy_o             = r_busy;
  assign done_tick_cordic_o = r_done;

endmodule
